// File: rtl/pc_unit.sv
// pc_unit -- program-counter stage at the front of the five-stage pipeline.
//
// Owns the PC register. After reset it fetches the 32-bit reset vector from
// data memory as two 16-bit words (low word, then high word). On an accepted
// interrupt it saves the current PC in epc and fetches the interrupt vector
// the same way. In RUN it registers the next-PC choice every cycle.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   stall             hold the PC this cycle (hazard unit)
//   next_pc_sel       00 pc+1, 01 branch_target, 10 ret_target, 11 hold
//   branch_target     resolved branch/jump/call address
//   ret_target        return address popped from the stack
//   int_req           external interrupt request (synchronous to clk)
//   mem_rdata         data-memory read data, combinational for mem_addr
//   mem_addr, mem_rd  vector-fetch address and read strobe
//   pc, pc_valid      current PC and "pc is fetchable"
//   epc               PC saved on interrupt entry
//   int_ack           one-cycle pulse while in the first interrupt-fetch cycle
module pc_unit #(
   parameter int PC_WIDTH  = 32,
   parameter int MEM_WIDTH = 16,
   parameter int RESET_VEC = 0,
   parameter int INT_VEC   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic [1:0]           next_pc_sel,
   input  logic [PC_WIDTH-1:0]  branch_target,
   input  logic [PC_WIDTH-1:0]  ret_target,
   input  logic                 int_req,
   input  logic [MEM_WIDTH-1:0] mem_rdata,
   output logic [MEM_WIDTH-1:0] mem_addr,
   output logic                 mem_rd,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 pc_valid,
   output logic [PC_WIDTH-1:0]  epc,
   output logic                 int_ack
);

   typedef enum logic [2:0] {BOOT_LO, BOOT_HI, RUN, INT_LO, INT_HI} state_t;

   state_t               state, state_nxt;
   logic                 int_req_d;
   logic                 pending;
   logic                 int_edge;
   logic                 accept;
   logic [PC_WIDTH-1:0]  pc_nxt;

   // Only the rising edge counts, so a request held high enters once.
   assign int_edge = int_req & ~int_req_d;
   // Interrupt entry outranks stall-free redirects; a stall defers it.
   assign accept   = (state == RUN) & pending & ~stall;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= BOOT_LO;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         BOOT_LO: state_nxt = BOOT_HI;
         BOOT_HI: state_nxt = RUN;
         RUN:     if (accept) state_nxt = INT_LO;
         INT_LO:  state_nxt = INT_HI;
         INT_HI:  state_nxt = RUN;
         default: state_nxt = BOOT_LO;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      mem_rd   = 1'b1;
      mem_addr = '0;
      pc_valid = 1'b0;
      case (state)
         BOOT_LO: mem_addr = MEM_WIDTH'(RESET_VEC);
         BOOT_HI: mem_addr = MEM_WIDTH'(RESET_VEC + 1);
         INT_LO:  mem_addr = MEM_WIDTH'(INT_VEC);
         INT_HI:  mem_addr = MEM_WIDTH'(INT_VEC + 1);
         default: begin
            mem_rd   = 1'b0;
            pc_valid = (state == RUN);
         end
      endcase
   end

   // Next PC: vector halves while fetching, selector choice in RUN.
   always_comb begin
      pc_nxt = pc;
      case (state)
         BOOT_LO, INT_LO: pc_nxt[MEM_WIDTH-1:0]        = mem_rdata;
         BOOT_HI, INT_HI: pc_nxt[PC_WIDTH-1:MEM_WIDTH] = mem_rdata;
         RUN: begin
            // On acceptance the selector is discarded and pc is held for epc.
            if (!accept && !stall) begin
               case (next_pc_sel)
                  2'b00:   pc_nxt = pc + PC_WIDTH'(1);   // wraps modulo 2^PC_WIDTH
                  2'b01:   pc_nxt = branch_target;
                  2'b10:   pc_nxt = ret_target;
                  default: pc_nxt = pc;
               endcase
            end
         end
         default: pc_nxt = pc;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= '0;
         epc       <= '0;
         int_ack   <= 1'b0;
         pending   <= 1'b0;
         int_req_d <= 1'b0;
      end else begin
         pc        <= pc_nxt;
         int_ack   <= accept;
         int_req_d <= int_req;
         // A new edge landing on the acceptance cycle must not be lost.
         pending   <= int_edge | (pending & ~accept);
         if (accept) epc <= pc;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [1:0]  next_pc_sel;
   logic [31:0] branch_target;
   logic [31:0] ret_target;
   logic        int_req;
   logic [15:0] mem_rdata;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [31:0] pc;
   logic        pc_valid;
   logic [31:0] epc;
   logic        int_ack;

   logic [15:0] mem [0:3];

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: vector fetches are "words still to fetch" from a base.
   logic [31:0] m_pc, m_epc;
   logic        m_pend, m_prev, m_ack;
   int          fetch_left;
   int          vbase;

   always #5 clk = ~clk;

   assign mem_rdata = (mem_addr[15:2] == 14'd0) ? mem[mem_addr[1:0]] : 16'h0;

   pc_unit #(.PC_WIDTH(32), .MEM_WIDTH(16), .RESET_VEC(0), .INT_VEC(2)) dut (
      .clk(clk), .rst(rst), .stall(stall), .next_pc_sel(next_pc_sel),
      .branch_target(branch_target), .ret_target(ret_target),
      .int_req(int_req), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .pc(pc), .pc_valid(pc_valid), .epc(epc),
      .int_ack(int_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_epc = 0; m_pend = 0; m_prev = 0; m_ack = 0;
      fetch_left = 2; vbase = 0;
   endtask

   // Called at a negedge; asserts rst asynchronously and releases it at a later negedge.
   task automatic do_reset();
      rst = 1'b1; int_req = 1'b0; stall = 1'b0; next_pc_sel = 2'b00;
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'd0, pc_valid}, 32'd0);
      chk("rst_ack", {31'd0, int_ack}, 32'd0);
      chk("rst_epc", epc, 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One cycle: drive at negedge, check fetch port, advance model, check after posedge.
   task automatic step(input logic s, input logic [1:0] sel, input logic [31:0] bt,
                       input logic [31:0] rt, input logic irq);
      logic edge_i, acc;
      int   idx;
      stall = s; next_pc_sel = sel; branch_target = bt; ret_target = rt; int_req = irq;
      #1;
      idx = vbase + 2 - fetch_left;
      if (fetch_left > 0) begin
         chk("mem_rd", {31'd0, mem_rd}, 32'd1);
         chk("mem_addr", {16'd0, mem_addr}, idx);
      end else begin
         chk("mem_rd", {31'd0, mem_rd}, 32'd0);
         chk("mem_addr", {16'd0, mem_addr}, 32'd0);
      end
      edge_i = irq & ~m_prev;
      m_prev = irq;
      acc    = 1'b0;
      if (fetch_left > 0) begin
         if (fetch_left == 2) m_pc[15:0]  = mem[idx];
         else                 m_pc[31:16] = mem[idx];
         fetch_left--;
      end else if (m_pend && !s) begin
         acc = 1'b1; m_epc = m_pc; fetch_left = 2; vbase = 2;
      end else if (!s) begin
         case (sel)
            2'd0: m_pc = m_pc + 1;
            2'd1: m_pc = bt;
            2'd2: m_pc = rt;
            default: ;
         endcase
      end
      m_pend = edge_i | (m_pend & ~acc);
      m_ack  = acc;
      @(posedge clk);
      #1;
      chk("pc", pc, m_pc);
      chk("epc", epc, m_epc);
      chk("pc_valid", {31'd0, pc_valid}, (fetch_left == 0) ? 32'd1 : 32'd0);
      chk("int_ack", {31'd0, int_ack}, {31'd0, m_ack});
      @(negedge clk);
   endtask

   initial begin
      int guard;
      rst = 1'b1; stall = 0; next_pc_sel = 0; branch_target = 0; ret_target = 0; int_req = 0;
      mem[0] = 16'h1234; mem[1] = 16'h0000; mem[2] = 16'h0200; mem[3] = 16'h0000;
      @(negedge clk);
      do_reset();

      // Boot, then redirect / stall / hold.
      step(0, 2'd0, 0, 0, 0);
      step(0, 2'd0, 0, 0, 0);
      chk("boot_pc", pc, 32'h00001234);
      step(0, 2'd1, 32'h40, 32'h0, 0);
      step(0, 2'd2, 32'h0, 32'h80, 0);
      step(1, 2'd1, 32'h999, 32'h0, 0);
      step(0, 2'd3, 32'h999, 32'h0, 0);
      chk("hold_pc", pc, 32'h80);

      // Interrupt pulse from pc=0x50, then held high: one entry only.
      step(0, 2'd1, 32'h50, 32'h0, 0);
      step(0, 2'd3, 0, 0, 1);
      step(0, 2'd3, 0, 0, 0);
      chk("int_epc", epc, 32'h50);
      for (int i = 0; i < 3; i++) step(0, 2'd3, 0, 0, 0);
      chk("int_pc", pc, 32'h200);
      for (int i = 0; i < 10; i++) step(0, 2'd3, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 2'd0, 0, 0, 1);

      // Sequential wrap.
      mem[0] = 16'hFFFE; mem[1] = 16'hFFFF;
      do_reset();
      step(0, 2'd0, 0, 0, 0);
      step(0, 2'd0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 0, 0);
      chk("wrap_pc", pc, 32'h1);

      // Edge during BOOT_LO, then 4 stalled RUN cycles before entry.
      mem[0] = 16'h0777; mem[1] = 16'h0000;
      do_reset();
      step(0, 2'd0, 0, 0, 1);
      step(0, 2'd0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 2'd1, 32'h123, 0, 1);
      step(0, 2'd1, 32'h123, 0, 1);
      chk("stall_epc", epc, 32'h777);
      for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 0, 0);

      // Randomized run against the model.
      for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
      do_reset();
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) == 0, 2'($urandom), $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? ~int_req : int_req);

      // Reset asserted while in INT_HI.
      step(0, 2'd0, 0, 0, 0);
      step(0, 2'd0, 0, 0, 1);
      guard = 0;
      while (fetch_left != 1 && guard < 20) begin
         step(0, 2'd0, 0, 0, 0);
         guard++;
      end
      chk("reach_int_hi", guard < 20, 1);
      do_reset();
      step(0, 2'd0, 0, 0, 0);
      step(0, 2'd0, 0, 0, 0);
      step(0, 2'd0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage at the front of the five-stage pipeline. It owns the PC register, loads the reset and interrupt vectors from data memory, and registers the next-PC choice every cycle. It consumes the branch and return targets that the later stages resolve through the 2-bit selector mux path. Its `pc` output drives instruction-memory addressing and the IF/ID buffer.

## Interface
- `PC_WIDTH`, 32: PC and target width; must equal 2×`MEM_WIDTH`.
- `MEM_WIDTH`, 16: data-memory word width.
- `RESET_VEC`, 0: address of the reset-vector low word; the high word is at `RESET_VEC`+1.
- `INT_VEC`, 2: address of the interrupt-vector low word; the high word is at `INT_VEC`+1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: hold the PC this cycle (from hazard unit).
- `next_pc_sel` in 2: 00 pc+1, 01 `branch_target`, 10 `ret_target`, 11 hold.
- `branch_target` in `PC_WIDTH`: resolved branch/jump/call address.
- `ret_target` in `PC_WIDTH`: return address (RET/RTI) popped from the stack.
- `int_req` in 1: external interrupt request, asynchronous to instruction flow, synchronous to `clk`.
- `mem_rdata` in `MEM_WIDTH`: data-memory read data, combinational for `mem_addr`.
- `mem_addr` out `MEM_WIDTH`: vector-fetch address.
- `mem_rd` out 1: vector-fetch read strobe.
- `pc` out `PC_WIDTH`: current PC.
- `pc_valid` out 1: `pc` is a fetchable address.
- `epc` out `PC_WIDTH`: PC saved on interrupt entry, for the pipeline to push.
- `int_ack` out 1: one-cycle pulse on interrupt acceptance.

## Operation
- States: BOOT_LO, BOOT_HI, RUN, INT_LO, INT_HI.
- Reset (async, any state):
  - state=BOOT_LO.
  - `pc`=0, `epc`=0, `pc_valid`=0, `int_ack`=0, pending=0, edge register=0.
- Outputs decoded from state:
  - BOOT_LO: `mem_rd`=1, `mem_addr`=`RESET_VEC`.
  - BOOT_HI: `mem_rd`=1, `mem_addr`=`RESET_VEC`+1.
  - INT_LO: `mem_rd`=1, `mem_addr`=`INT_VEC`.
  - INT_HI: `mem_rd`=1, `mem_addr`=`INT_VEC`+1.
  - RUN: `mem_rd`=0, `mem_addr`=0.
  - `pc_valid`=1 only in RUN.
- Vector states:
  - BOOT_LO: `pc[15:0]`←`mem_rdata`, go to BOOT_HI.
  - BOOT_HI: `pc[31:16]`←`mem_rdata`, go to RUN.
  - INT_LO and INT_HI: identical, then return to RUN.
  - `stall` and `next_pc_sel` are ignored in all four vector states.
- Interrupt pending:
  - pending is set on a registered rising edge of `int_req` (`int_req` & ~`int_req_d`) in any state, including boot.
  - pending is cleared on entry to INT_LO.
  - If a new edge coincides with the clear, set wins.
- RUN, highest priority first:
  1. pending & ~`stall`: `epc`←`pc`, `int_ack`=1 next cycle, go to INT_LO. `next_pc_sel` is discarded.
  2. `stall`: hold `pc`. Pending stays latched.
  3. Otherwise, update per `next_pc_sel`.
- pc+1 is modulo 2^`PC_WIDTH`: 0xFFFFFFFF → 0x00000000.
- `int_req` held high generates exactly one interrupt.

## Timing
- After `rst` falls:
  - edge 1 loads the low half;
  - edge 2 loads the high half;
  - `pc_valid`=1 after edge 2, with `pc` equal to the full vector.
- Boot latency: 2 cycles. Interrupt entry: 3 cycles from the accepting edge until `pc_valid` returns (INT_LO, INT_HI, then RUN).
- `int_req` rising at edge N sets pending after edge N+1. It is accepted at edge N+2 if in RUN and unstalled.
- `int_ack` is high for exactly the INT_LO cycle.
- `epc` updates only on acceptance and is otherwise stable.
- Redirect: a registered `next_pc_sel`/target choice appears on `pc` one edge later.
- Reset asserted mid-INT_HI: `pc`=0 immediately, pending cleared, boot restarts.

## Test plan
- Reset boot: M[0]=0x1234, M[1]=0x0000 → after 2 edges `pc`=0x00001234, `pc_valid`=1. During boot, `mem_addr`=0 then 1 and `mem_rd`=1.
- Sequential and wrap: boot to 0xFFFFFFFE, sel=00 for 3 cycles → `pc` = 0xFFFFFFFF, 0x00000000, 0x00000001.
- Redirect and stall:
  - sel=01, `branch_target`=0x40 → `pc`=0x40.
  - sel=10, `ret_target`=0x80 → `pc`=0x80.
  - `stall`=1 with sel=01 → `pc` holds.
  - sel=11 → `pc` holds.
- Interrupt:
  - setup: `pc`=0x50, M[2]=0x0200, M[3]=0.
  - stimulus: pulse `int_req`.
  - response: `int_ack` 1 cycle, `epc`=0x50, `pc_valid` low 2 cycles, then `pc`=0x200.
  - `int_req` held high → no second entry.
- Interrupt under stall and during boot:
  - edge during BOOT_LO → taken on first unstalled RUN cycle.
  - `stall`=1 for 4 cycles with pending → no entry until `stall`=0, `epc` = stalled `pc`.
- Async reset mid-interrupt: assert `rst` in INT_HI → `pc`=0, `pc_valid`=0 and `int_ack`=0 at once, no clock edge needed. Boot resumes from `RESET_VEC` when `rst` falls.
